// File: rtl/run_control_rv32_pkg.sv
// run_control_rv32_pkg: shared types and constants for the rv32 run controller
//   XLEN                : core data/address width
//   EBREAK_INSN         : default halt instruction encoding
//   DEFAULT_TOHOST_ADDR : default store address that ends a run
//   state_e             : run controller FSM states
//   halt_e              : cause of a halt detected in an enabled cycle
package run_control_rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] EBREAK_INSN = 32'h0010_0073;
  localparam logic [XLEN-1:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_HALTED
  } state_e;
  typedef enum logic [1:0] {
    HALT_NONE,
    HALT_TOHOST,
    HALT_EBREAK,
    HALT_TIMEOUT
  } halt_e;
  function automatic logic core_enabled(input state_e s);
    return s == ST_RUN || s == ST_STEP_EXEC;
  endfunction
  function automatic logic accepts_start(input state_e s);
    return s == ST_IDLE || s == ST_HALTED;
  endfunction
endpackage

// File: rtl/run_control_rv32_trace.sv
// run_control_rv32_trace: circular buffer of the most recent core PCs
//   clock_i   : clock
//   reset_n_i : synchronous reset, active low (clears pointers and read data)
//   wr_en_i   : push wr_data_i; when full the oldest entry is overwritten
//   wr_data_i : PC to record
//   rd_en_i   : pop the oldest entry; rd_data_o valid after one clock
//   rd_data_o : last popped PC
//   empty_o   : no entries stored
module run_control_rv32_trace
  import run_control_rv32_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic            rd_en_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic [XLEN-1:0] rd_data_q;
  logic full, pop;
  always_comb begin
    full = count_q == (AW+1)'(DEPTH);
    pop = rd_en_i && count_q != '0;
  end
  always_ff @(posedge clock_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end
  // Writes and pops never coincide in practice; a write takes precedence.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rd_data_q <= '0;
    end else if (wr_en_i) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= full ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q <= full ? count_q : count_q + 1'b1;
    end else if (pop) begin
      rd_data_q <= mem_q[rd_ptr_q];
      rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q - 1'b1;
    end
  end
  assign rd_data_o = rd_data_q;
  assign empty_o = count_q == '0;
endmodule

// File: rtl/run_control_rv32.sv
// run_control_rv32: run controller sequencing the rv32i core enable
//   Free-run and single-step modes, cycle/retired counters, halt on EBREAK,
//   TOHOST store or cycle timeout, with pass/fail and exit code reporting.
//   Optional PC trace buffer enabled by defining RUN_CONTROL_TRACE_EN.
//   clock_i/reset_n_i       : clock, synchronous active-low reset
//   start_i                 : pulse, clear status and begin a run (IDLE/HALTED only)
//   step_mode_i, step_i     : single-step mode select and step pulse
//   pc_i, instruction_i     : current core PC and fetched instruction
//   store_valid_i/address/data : core store bus
//   enable_o, running_o     : core enable, run in progress
//   done_o, pass_o, timeout_o, exit_code_o : run result
//   cycle_counter_o, retired_count_o : enabled / retired cycles of this run
//   trace_rd_en_i, trace_rd_data_o, trace_empty_o : PC trace read port
module run_control_rv32
  import run_control_rv32_pkg::*;
#(
  parameter int                CYCLE_WIDTH      = 32,
  parameter int                MAX_CYCLES       = 50,
  parameter logic [XLEN-1:0]   TOHOST_ADDR      = DEFAULT_TOHOST_ADDR,
  parameter logic [XLEN-1:0]   HALT_INSTRUCTION = EBREAK_INSN,
  parameter int                TRACE_DEPTH      = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   step_mode_i,
  input  logic                   step_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        instruction_i,
  input  logic                   store_valid_i,
  input  logic [XLEN-1:0]        store_address_i,
  input  logic [XLEN-1:0]        store_data_i,
  output logic                   enable_o,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [XLEN-1:0]        exit_code_o,
  output logic [CYCLE_WIDTH-1:0] cycle_counter_o,
  output logic [CYCLE_WIDTH-1:0] retired_count_o,
  input  logic                   trace_rd_en_i,
  output logic [XLEN-1:0]        trace_rd_data_o,
  output logic                   trace_empty_o
);
  state_e state_q, state_d;
  halt_e cause;
  logic start_q, enable_q, running_q, done_q, pass_q, timeout_q, clear, timeout_hit;
  logic [XLEN-1:0] exit_code_q;
  logic [CYCLE_WIDTH-1:0] cycle_q, retired_q, cycle_inc, retired_inc;
  // start is registered first, so enable rises two edges after the pulse.
  always_comb begin
    clear = accepts_start(state_q) && start_q;
    timeout_hit = (MAX_CYCLES != 0) && (cycle_q == CYCLE_WIDTH'(MAX_CYCLES - 1));
    cause = !enable_q ? HALT_NONE :
            (store_valid_i && store_address_i == TOHOST_ADDR) ? HALT_TOHOST :
            (instruction_i == HALT_INSTRUCTION) ? HALT_EBREAK :
            timeout_hit ? HALT_TIMEOUT : HALT_NONE;
    cycle_inc = &cycle_q ? cycle_q : cycle_q + 1'b1;
    retired_inc = &retired_q ? retired_q : retired_q + 1'b1;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALTED: state_d = !start_q ? state_q : step_mode_i ? ST_STEP_WAIT : ST_RUN;
      ST_STEP_WAIT: state_d = !step_mode_i ? ST_RUN : step_i ? ST_STEP_EXEC : ST_STEP_WAIT;
      ST_RUN, ST_STEP_EXEC: state_d = cause != HALT_NONE ? ST_HALTED :
                                      (state_q == ST_RUN && !step_mode_i) ? ST_RUN : ST_STEP_WAIT;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      enable_q <= 1'b0;
      running_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      timeout_q <= 1'b0;
      exit_code_q <= '0;
      cycle_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      enable_q <= core_enabled(state_d);
      running_q <= !accepts_start(state_d);
      if (clear) begin
        done_q <= 1'b0;
        pass_q <= 1'b0;
        timeout_q <= 1'b0;
        exit_code_q <= '0;
        cycle_q <= '0;
        retired_q <= '0;
      end else if (enable_q) begin
        cycle_q <= cycle_inc;
        retired_q <= cause == HALT_NONE ? retired_inc : retired_q;
        if (cause != HALT_NONE) begin
          done_q <= 1'b1;
          pass_q <= cause == HALT_TOHOST ? store_data_i == 32'd1 : cause == HALT_EBREAK;
          timeout_q <= cause == HALT_TIMEOUT;
          exit_code_q <= cause == HALT_TOHOST ? store_data_i : '0;
        end
      end
    end
  end
  assign enable_o = enable_q;
  assign running_o = running_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
  assign timeout_o = timeout_q;
  assign exit_code_o = exit_code_q;
  assign cycle_counter_o = cycle_q;
  assign retired_count_o = retired_q;
`ifdef RUN_CONTROL_TRACE_EN
  // Pops are only honoured while the core is stopped.
  run_control_rv32_trace #(.DEPTH(TRACE_DEPTH)) u_trace (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .wr_en_i   (enable_q),
    .wr_data_i (pc_i),
    .rd_en_i   (trace_rd_en_i && accepts_start(state_q)),
    .rd_data_o (trace_rd_data_o),
    .empty_o   (trace_empty_o)
  );
`else
  logic unused_trace;
  assign unused_trace = &{1'b0, trace_rd_en_i, pc_i, (TRACE_DEPTH > 0)};
  assign trace_rd_data_o = '0;
  assign trace_empty_o = 1'b1;
`endif
endmodule

// File: tb/tb_run_control_rv32.sv
// tb_run_control_rv32: directed self-checking bench for run_control_rv32
module tb_run_control_rv32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [31:0] insn;
    int          trig;
    logic        pass;
    logic        tmo;
    logic [31:0] exitc;
    logic [31:0] cyc;
    logic [31:0] ret;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, start, start_b, step_mode, step, store_valid, trace_rd_en;
  logic [31:0] pc, instruction, store_address, store_data;
  logic enable, running, done, pass, timeout, trace_empty;
  logic [31:0] exit_code, cycle_counter, retired_count, trace_rd_data;
  logic b_enable, b_running, b_done, b_pass, b_timeout, b_trace_empty;
  logic [31:0] b_exit_code, b_trace_rd_data;
  logic [3:0] b_cycle, b_retired;
  int total = 0;
  int passed = 0;
  vec_t vecs [9];
  vec_t trace_v;

  run_control_rv32 dut (
    .clock_i(clk), .reset_n_i(reset_n), .start_i(start), .step_mode_i(step_mode), .step_i(step),
    .pc_i(pc), .instruction_i(instruction), .store_valid_i(store_valid),
    .store_address_i(store_address), .store_data_i(store_data),
    .enable_o(enable), .running_o(running), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .exit_code_o(exit_code), .cycle_counter_o(cycle_counter), .retired_count_o(retired_count),
    .trace_rd_en_i(trace_rd_en), .trace_rd_data_o(trace_rd_data), .trace_empty_o(trace_empty)
  );

  run_control_rv32 #(.CYCLE_WIDTH(4), .MAX_CYCLES(0)) dut_b (
    .clock_i(clk), .reset_n_i(reset_n), .start_i(start_b), .step_mode_i(step_mode), .step_i(step),
    .pc_i(pc), .instruction_i(instruction), .store_valid_i(store_valid),
    .store_address_i(store_address), .store_data_i(store_data),
    .enable_o(b_enable), .running_o(b_running), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_timeout),
    .exit_code_o(b_exit_code), .cycle_counter_o(b_cycle), .retired_count_o(b_retired),
    .trace_rd_en_i(1'b0), .trace_rd_data_o(b_trace_rd_data), .trace_empty_o(b_trace_empty)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_nop;
    store_valid = 1'b0;
    store_address = 32'h0;
    store_data = 32'h0;
    instruction = NOP;
    step = 1'b0;
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    logic hit;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int n = 0; n < 200 && !done; n++) begin
      hit = enable && (cycle_counter == 32'(v.trig));
      store_valid = hit && v.sv;
      store_address = hit ? v.sa : 32'h0;
      store_data = hit ? v.sd : 32'h0;
      instruction = hit ? v.insn : NOP;
      pc = 32'h100 + (cycle_counter << 2);
      tick;
    end
    set_nop;
    chk($sformatf("%s.done", tag), 32'(done), 32'd1);
    chk($sformatf("%s.enable", tag), 32'(enable), 32'd0);
    chk($sformatf("%s.running", tag), 32'(running), 32'd0);
    chk($sformatf("%s.pass", tag), 32'(pass), 32'(v.pass));
    chk($sformatf("%s.timeout", tag), 32'(timeout), 32'(v.tmo));
    chk($sformatf("%s.exit_code", tag), exit_code, v.exitc);
    chk($sformatf("%s.cycle_counter", tag), cycle_counter, v.cyc);
    chk($sformatf("%s.retired_count", tag), retired_count, v.ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0, 32'h0, EBRK, 7, 1'b1, 1'b0, 32'd0, 32'd8, 32'd7};
    vecs[1] = '{1'b1, 32'h1000, 32'h1, NOP, 3, 1'b1, 1'b0, 32'd1, 32'd4, 32'd3};
    vecs[2] = '{1'b1, 32'h1000, 32'h5, NOP, 3, 1'b0, 1'b0, 32'd5, 32'd4, 32'd3};
    vecs[3] = '{1'b0, 32'h0, 32'h0, NOP, 999, 1'b0, 1'b1, 32'd0, 32'd50, 32'd49};
    vecs[4] = '{1'b1, 32'h1000, 32'h7, EBRK, 2, 1'b0, 1'b0, 32'd7, 32'd3, 32'd2};
    vecs[5] = '{1'b1, 32'h1004, 32'h1, NOP, 4, 1'b0, 1'b1, 32'd0, 32'd50, 32'd49};
    vecs[6] = '{1'b0, 32'h0, 32'h0, EBRK, 0, 1'b1, 1'b0, 32'd0, 32'd1, 32'd0};
    vecs[7] = '{1'b1, 32'h1000, 32'h1, NOP, 49, 1'b1, 1'b0, 32'd1, 32'd50, 32'd49};
    vecs[8] = '{1'b0, 32'h0, 32'h0, EBRK, 48, 1'b1, 1'b0, 32'd0, 32'd49, 32'd48};
    trace_v = '{1'b0, 32'h0, 32'h0, EBRK, 20, 1'b1, 1'b0, 32'd0, 32'd21, 32'd20};
    reset_n = 1'b0;
    start = 1'b0;
    start_b = 1'b0;
    step_mode = 1'b0;
    trace_rd_en = 1'b0;
    pc = 32'h100;
    set_nop;
    tick;
    tick;
    chk("reset.enable", 32'(enable), 32'd0);
    chk("reset.running", 32'(running), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.cycle_counter", cycle_counter, 32'd0);
    chk("reset.trace_empty", 32'(trace_empty), 32'd1);
    reset_n = 1'b1;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("latency.edge1.enable", 32'(enable), 32'd0);
    tick;
    chk("latency.edge2.enable", 32'(enable), 32'd1);
    chk("latency.edge2.running", 32'(running), 32'd1);
    chk("latency.edge2.cycle_counter", cycle_counter, 32'd0);
    repeat (5) tick;
    chk("midrun.cycle_counter", cycle_counter, 32'd5);
    reset_n = 1'b0;
    tick;
    chk("midreset.enable", 32'(enable), 32'd0);
    chk("midreset.running", 32'(running), 32'd0);
    chk("midreset.done", 32'(done), 32'd0);
    chk("midreset.pass", 32'(pass), 32'd0);
    chk("midreset.timeout", 32'(timeout), 32'd0);
    chk("midreset.exit_code", exit_code, 32'd0);
    chk("midreset.cycle_counter", cycle_counter, 32'd0);
    chk("midreset.retired_count", retired_count, 32'd0);
    chk("midreset.trace_empty", 32'(trace_empty), 32'd1);
    chk("midreset.trace_rd_data", trace_rd_data, 32'd0);
    reset_n = 1'b1;
    tick;
    for (int i = 0; i < 9; i++) run_vector(vecs[i], $sformatf("vec%0d", i));
    step_mode = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("step.wait.running", 32'(running), 32'd1);
    chk("step.wait.enable", 32'(enable), 32'd0);
    chk("step.wait.done_cleared", 32'(done), 32'd0);
    repeat (2) tick;
    chk("step.idle.cycle_counter", cycle_counter, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick;
      step = 1'b0;
      chk($sformatf("step%0d.enable_hi", k), 32'(enable), 32'd1);
      tick;
      chk($sformatf("step%0d.enable_lo", k), 32'(enable), 32'd0);
      chk($sformatf("step%0d.cycle_counter", k), cycle_counter, 32'(k + 1));
    end
    step_mode = 1'b0;
    tick;
    chk("step.to_run.enable", 32'(enable), 32'd1);
    step_mode = 1'b1;
    tick;
    chk("step.back_wait.enable", 32'(enable), 32'd0);
    chk("step.back_wait.cycle_counter", cycle_counter, 32'd4);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (2) tick;
    chk("step.start_ignored.cycle_counter", cycle_counter, 32'd4);
    chk("step.start_ignored.running", 32'(running), 32'd1);
    instruction = EBRK;
    step = 1'b1;
    tick;
    step = 1'b0;
    tick;
    instruction = NOP;
    step_mode = 1'b0;
    chk("step.halt.done", 32'(done), 32'd1);
    chk("step.halt.pass", 32'(pass), 32'd1);
    chk("step.halt.enable", 32'(enable), 32'd0);
    chk("step.halt.cycle_counter", cycle_counter, 32'd5);
    chk("step.halt.retired_count", retired_count, 32'd4);
`ifdef RUN_CONTROL_TRACE_EN
    run_vector(trace_v, "trace");
    trace_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      chk($sformatf("trace.pop%0d", i), trace_rd_data, 32'h100 + 32'(4 * (5 + i)));
    end
    trace_rd_en = 1'b0;
    chk("trace.empty_after", 32'(trace_empty), 32'd1);
    trace_rd_en = 1'b1;
    tick;
    trace_rd_en = 1'b0;
    chk("trace.pop_empty.data", trace_rd_data, 32'h150);
    chk("trace.pop_empty.empty", 32'(trace_empty), 32'd1);
`else
    run_vector(trace_v, "trace");
    trace_rd_en = 1'b1;
    tick;
    trace_rd_en = 1'b0;
    chk("notrace.empty", 32'(trace_empty), 32'd1);
    chk("notrace.data", trace_rd_data, 32'd0);
`endif
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    repeat (201) tick;
    chk("nolimit.running", 32'(b_running), 32'd1);
    chk("nolimit.enable", 32'(b_enable), 32'd1);
    chk("nolimit.done", 32'(b_done), 32'd0);
    chk("nolimit.timeout", 32'(b_timeout), 32'd0);
    chk("nolimit.pass", 32'(b_pass), 32'd0);
    chk("nolimit.exit_code", b_exit_code, 32'd0);
    chk("sat.cycle_counter", 32'(b_cycle), 32'd15);
    chk("sat.retired_count", 32'(b_retired), 32'd15);
    chk("nolimit.trace_empty", 32'(b_trace_empty), 32'd1);
    chk("nolimit.trace_rd_data", b_trace_rd_data, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
